// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for the RISC-V M-extension multiply ops (MUL/MULH/MULHSU/MULHU).
// Fixed latency of WIDTH+1 cycles from an accepted start to the done strobe.
module mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCompute, StFinish} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   // Low accumulator half doubles as the multiplier shift register.
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [1:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;

   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     addend, sum;
   logic [2*WIDTH-1:0] prod_abs, prod;

   always_comb begin
      sign_a = a[WIDTH-1] & ((op == 2'b01) | (op == 2'b10));
      sign_b = b[WIDTH-1] & (op == 2'b01);
      // The most negative value maps to its own bit pattern, which is the correct magnitude.
      mag_a  = sign_a ? ('0 - a) : a;
      mag_b  = sign_b ? ('0 - b) : b;

      addend   = acc_lo_q[0] ? {1'b0, mcand_q} : '0;
      sum      = {1'b0, acc_hi_q} + addend;
      prod_abs = {acc_hi_q, acc_lo_q};
      prod     = neg_q ? ('0 - prod_abs) : prod_abs;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StCompute;
               mcand_d  = mag_a;
               acc_lo_d = mag_b;
               acc_hi_d = '0;
               cnt_d    = '0;
               op_d     = op;
               neg_d    = sign_a ^ sign_b;
            end
         end
         StCompute: begin
            acc_hi_d = sum[WIDTH:1];
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            result_d = (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
            done_d   = 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         op_q     <= 2'b00;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, handshake/reset behaviour and
// randomized back-to-back operations against a 2*WIDTH-bit arithmetic reference.
module tb_mul_seq;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int start_cyc = 0;

   mul_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sign-extend or zero-extend each operand as the op dictates, then take the wide product.
   function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      logic [2*W-1:0] xe, ye, p;
      xe = (o == 2'b01 || o == 2'b10) ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ye = (o == 2'b01) ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      p  = xe * ye;
      return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Called just after a rising edge; start is sampled at the next edge.
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start     = 1'b0;
      a         = $urandom;
      b         = $urandom;
      op        = 2'($urandom);
   endtask

   // Returns in the done cycle so a following start_op is back-to-back.
   task automatic wait_done(input string tag, input logic [W-1:0] exp);
      bit seen = 1'b0;
      bit overlap = 1'b0;
      bit busy_drop = 1'b0;
      for (int i = 0; i < int'(W) + 8 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (busy && done) overlap = 1'b1;
         if (done) seen = 1'b1;
         else if (!busy) busy_drop = 1'b1;
      end
      check({tag, "_done_seen"}, W'(seen), W'(1));
      check({tag, "_busy_done_excl"}, W'(overlap), W'(0));
      check({tag, "_busy_held"}, W'(busy_drop), W'(0));
      if (seen) begin
         check({tag, "_latency"}, W'(cyc - start_cyc), W'(W + 1));
         check({tag, "_result"}, result, exp);
      end
   endtask

   initial begin
      bit seen_done;
      logic [1:0]   o;
      logic [W-1:0] x, y;

      #2 reset = 1'b1;
      #2;
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_result", result, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      start_op(2'b00, 32'd7, 32'hFFFF_FFFD);
      wait_done("mul_7_m3", 32'hFFFF_FFEB);
      @(posedge clk);
      #1;
      check("done_pulse_width", W'(done), W'(0));
      check("idle_busy", W'(busy), W'(0));
      check("result_held", result, 32'hFFFF_FFEB);

      start_op(2'b01, 32'h8000_0000, 32'h8000_0000);
      wait_done("mulh_min", 32'h4000_0000);
      start_op(2'b11, 32'h8000_0000, 32'h8000_0000);
      wait_done("mulhu_min", 32'h4000_0000);
      start_op(2'b00, 32'h8000_0000, 32'h8000_0000);
      wait_done("mul_min", 32'h0000_0000);
      start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulhsu_m1", 32'hFFFF_FFFF);
      start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulhu_max", 32'hFFFF_FFFE);

      // A start pulse while busy must not re-sample operands.
      start_op(2'b11, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      #1;
      op    = 2'b00;
      a     = 32'd9;
      b     = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_start_ignored", 32'h0000_0000);
      start_op(2'b00, 32'd3, 32'd5);
      wait_done("b2b_mul", 32'd15);

      // Abort mid-operation with asynchronous reset.
      start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", W'(busy), W'(0));
      check("abort_done", W'(done), W'(0));
      check("abort_result", result, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < int'(W) + 8; i++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", W'(seen_done), W'(0));
      start_op(2'b01, 32'hFFFF_FFF9, 32'd6);
      wait_done("after_abort", ref_mul(2'b01, 32'hFFFF_FFF9, 32'd6));

      for (int n = 0; n < 2000; n++) begin
         o = 2'($urandom_range(0, 3));
         x = pick();
         y = pick();
         start_op(o, x, y);
         wait_done("rand", ref_mul(o, x, y));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
